program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/loader_pkg.sv | 28 ++
 rtl/program_loader.sv | 98 +++++++++
 tb/tb_program_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: the loader state encoding,
// the payload length implied by a zero length byte, and a small helper
// that turns a raw length byte into a payload byte count.
package loader_pkg;

    // Loader states, in the order a good frame passes through them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } loader_state_t;

    // A length byte of zero means a full 256-byte payload.
    localparam int LEN_ZERO_N = 256;

    // Payload byte count for a given length byte (1..256, needs 9 bits).
    function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
        return (len_byte == 8'h00) ? 9'(LEN_ZERO_N) : {1'b0, len_byte};
    endfunction

    // The loader takes bytes until a frame has been judged good or bad.
    function automatic logic takes_bytes(input loader_state_t st);
        return (st == IDLE) || (st == LOAD) || (st == CHECK);
    endfunction

endpackage

// File: rtl/program_loader.sv
// Program loader: parses a length/payload/checksum byte stream, writes the
// payload into instruction memory starting at BASE_ADDR (wrapping mod 256),
// and releases the processor reset only when the checksum matches.
// The cpu_reset output is meant to be ORed with the system reset at the
// processor. Memory contents written before a reset are left as they are.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_reset,
    output logic       done,
    output logic       error
);

    loader_state_t state;
    logic [8:0]    n_len;   // payload bytes expected in this frame (1..256)
    logic [8:0]    idx;     // payload bytes accepted so far
    logic [7:0]    acc;     // running mod-256 sum of the payload
    logic          accept;

    // Byte handshake: ready depends only on the registered state.
    assign in_ready = takes_bytes(state);
    assign accept   = in_valid && in_ready;

    // Frame parser, memory write port and status outputs, all registered.
    // NOTE: every register here is assigned with <= so each update sees the
    // values from before the edge; mixing in = would make the order of
    // statements change the hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            n_len     <= 9'd0;
            idx       <= 9'd0;
            acc       <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 8'd0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse unless a payload byte lands.
            mem_we <= 1'b0;

            if (restart) begin
                // Restart wins over any byte presented in the same cycle.
                state     <= IDLE;
                done      <= 1'b0;
                error     <= 1'b0;
                cpu_reset <= 1'b1;
            end else if (accept) begin
                case (state)
                    IDLE: begin
                        n_len <= frame_len(in_data);
                        idx   <= 9'd0;
                        acc   <= 8'd0;
                        state <= LOAD;
                    end
                    LOAD: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE_ADDR + idx[7:0];
                        mem_wdata <= in_data;
                        acc       <= acc + in_data;
                        idx       <= idx + 9'd1;
                        if (idx == n_len - 9'd1) begin
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (in_data == acc) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state     <= ERR;
                            error     <= 1'b1;
                            cpu_reset <= 1'b1;
                        end
                    end
                    default: begin
                        // DONE and ERR never accept a byte; they wait for restart.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader. Two instances (BASE_ADDR 00 and F0)
// see identical stimulus; a frame-level reference model predicts every
// cycle's outputs for both.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset, restart, in_valid;
    logic [7:0] in_data;

    logic       rdy0, we0, cpur0, dn0, er0;
    logic [7:0] addr0, wdata0;
    logic       rdy1, we1, cpur1, dn1, er1;
    logic [7:0] addr1, wdata1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    program_loader #(.BASE_ADDR(8'h00)) dut0 (
        .clk(clk), .reset(reset), .restart(restart),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
        .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .cpu_reset(cpur0), .done(dn0), .error(er0)
    );

    program_loader #(.BASE_ADDR(8'hF0)) dut1 (
        .clk(clk), .reset(reset), .restart(restart),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
        .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
        .cpu_reset(cpur1), .done(dn1), .error(er1)
    );

    // ---------------- reference model (frame position based) ----------------
    int         m_pos;      // 0: expecting length, 1..n: payload, n+1: checksum
    int         m_n;
    int         m_sum;
    int         m_status;   // 0 busy, 1 good checksum, 2 bad checksum
    bit         m_we;
    logic [7:0] m_addr [2];
    logic [7:0] m_wdata;

    // Observed write log.
    int         wcount [2];
    int         cover0 [256];
    int         cover1 [256];
    logic [7:0] seq1 [$];

    function automatic int base_of(input int i);
        return (i == 0) ? 'h00 : 'hF0;
    endfunction

    function automatic void model_edge(input bit v, input logic [7:0] d,
                                       input bit rs, input bit rst);
        m_we = 1'b0;
        if (rst) begin
            m_pos = 0; m_status = 0; m_sum = 0;
            m_addr[0] = 8'(base_of(0));
            m_addr[1] = 8'(base_of(1));
            m_wdata = 8'h00;
        end else if (rs) begin
            m_pos = 0; m_status = 0;
        end else if (v && m_status == 0) begin
            if (m_pos == 0) begin
                m_n   = (d == 8'h00) ? 256 : int'(d);
                m_sum = 0;
                m_pos = 1;
            end else if (m_pos <= m_n) begin
                m_we      = 1'b1;
                m_addr[0] = 8'((base_of(0) + m_pos - 1) % 256);
                m_addr[1] = 8'((base_of(1) + m_pos - 1) % 256);
                m_wdata   = d;
                m_sum     = (m_sum + int'(d)) % 256;
                m_pos     = m_pos + 1;
            end else begin
                m_status = (int'(d) == m_sum) ? 1 : 2;
                m_pos    = 0;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic       o_we [2], o_rdy [2], o_dn [2], o_er [2], o_cr [2];
        logic [7:0] o_addr [2], o_wd [2];
        o_we[0] = we0;  o_rdy[0] = rdy0; o_dn[0] = dn0; o_er[0] = er0; o_cr[0] = cpur0;
        o_addr[0] = addr0; o_wd[0] = wdata0;
        o_we[1] = we1;  o_rdy[1] = rdy1; o_dn[1] = dn1; o_er[1] = er1; o_cr[1] = cpur1;
        o_addr[1] = addr1; o_wd[1] = wdata1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("mem_we%0d", i),    32'(o_we[i]),  32'(m_we));
            check($sformatf("mem_addr%0d", i),  32'(o_addr[i]), 32'(m_addr[i]));
            check($sformatf("mem_wdata%0d", i), 32'(o_wd[i]),  32'(m_wdata));
            check($sformatf("in_ready%0d", i),  32'(o_rdy[i]), 32'(m_status == 0));
            check($sformatf("done%0d", i),      32'(o_dn[i]),  32'(m_status == 1));
            check($sformatf("error%0d", i),     32'(o_er[i]),  32'(m_status == 2));
            check($sformatf("cpu_reset%0d", i), 32'(o_cr[i]),  32'(m_status != 1));
            if (o_we[i] === 1'b1) begin
                wcount[i]++;
                if (i == 0) cover0[o_addr[i]]++;
                else begin
                    cover1[o_addr[i]]++;
                    seq1.push_back(o_addr[i]);
                end
            end
        end
    endtask

    // One clock cycle: drive inputs, advance, update the model, compare.
    task automatic step(input bit v, input logic [7:0] d, input bit rs, input bit rst);
        in_valid = v; in_data = d; restart = rs; reset = rst;
        @(posedge clk);
        model_edge(v, d, rs, rst);
        #1;
        compare_all();
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 1'b0);
    endtask

    // Whole frame: pattern 0 random payload, 1 payload k = byte k.
    task automatic send_frame(input logic [7:0] len_byte, input bit good,
                              input int pattern, input int max_gap);
        int         n, sum;
        logic [7:0] b;
        n   = (len_byte == 8'h00) ? 256 : int'(len_byte);
        sum = 0;
        send_byte(len_byte, max_gap);
        for (int k = 0; k < n; k++) begin
            b   = (pattern == 1) ? 8'(k) : 8'($urandom);
            sum = (sum + int'(b)) % 256;
            send_byte(b, max_gap);
        end
        send_byte(good ? 8'(sum) : 8'(sum) ^ 8'h5A, max_gap);
    endtask

    task automatic clear_log();
        wcount[0] = 0; wcount[1] = 0;
        for (int a = 0; a < 256; a++) begin cover0[a] = 0; cover1[a] = 0; end
        seq1.delete();
    endtask

    initial begin
        int once_bad;
        clear_log();
        m_pos = 0; m_n = 0; m_sum = 0; m_status = 0; m_we = 0; m_wdata = 0;
        m_addr[0] = 8'h00; m_addr[1] = 8'hF0;

        // Reset state, with restart and a byte presented to show reset dominates.
        step(1'b1, 8'h55, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("rst_addr_f0", 32'(addr1), 32'h0F0);
        check("rst_cpu_reset", 32'(cpur0), 32'd1);

        // Back-to-back good frame: 03 11 22 33 66.
        clear_log();
        send_byte(8'h03, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
        send_byte(8'h33, 0); send_byte(8'h66, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("f1_writes", 32'(wcount[0]), 32'd3);
        check("f1_done", 32'(dn0), 32'd1);
        check("f1_cpu_reset", 32'(cpur0), 32'd0);

        // Bad checksum: 02 AA BB 00 (correct is 65).
        step(1'b0, 8'h00, 1'b1, 1'b0);
        clear_log();
        send_byte(8'h02, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'h00, 0);
        step(1'b1, 8'h77, 1'b0, 1'b0);   // ignored: not ready
        check("f2_writes", 32'(wcount[0]), 32'd2);
        check("f2_error", 32'(er0), 32'd1);
        check("f2_in_ready", 32'(rdy0), 32'd0);

        // L=00, 256 bytes 00..FF, checksum 80.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        clear_log();
        send_frame(8'h00, 1'b1, 1, 0);
        check("f3_writes", 32'(wcount[0]), 32'd256);
        once_bad = 0;
        for (int a = 0; a < 256; a++) if (cover0[a] != 1 || cover1[a] != 1) once_bad++;
        check("f3_cover_once", 32'(once_bad), 32'd0);
        check("f3_done", 32'(dn1), 32'd1);

        // L=20 with the F0 instance: F0..FF then 00..0F.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        clear_log();
        send_frame(8'h20, 1'b1, 0, 2);
        check("f4_seq_len", 32'(seq1.size()), 32'd32);
        once_bad = 0;
        for (int j = 0; j < seq1.size(); j++) if (seq1[j] !== 8'(240 + j)) once_bad++;
        check("f4_seq_order", 32'(once_bad), 32'd0);

        // Restart after 2 of 5 payload bytes, byte presented with the restart.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        clear_log();
        send_byte(8'h05, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
        step(1'b1, 8'h03, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("f5_stale_writes", 32'(wcount[0]), 32'd2);
        send_frame(8'h05, 1'b1, 0, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("f5_total_writes", 32'(wcount[0]), 32'd7);
        check("f5_done", 32'(dn0), 32'd1);

        // Random frames with random gaps, good and bad checksums.
        for (int f = 0; f < 12; f++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            send_frame(8'($urandom_range(24, 1)), 1'($urandom_range(1, 0)), 0, 3);
            for (int g = 0; g < 3; g++) step(1'($urandom), 8'($urandom), 1'b0, 1'b0);
        end

        // Reset in mid-LOAD, then silence: no writes after the reset edge.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        send_byte(8'h10, 2);
        for (int k = 0; k < 6; k++) send_byte(8'($urandom), 2);
        step(1'b1, 8'hC3, 1'b1, 1'b1);
        check("r_mem_we", 32'(we0), 32'd0);
        check("r_mem_wdata", 32'(wdata0), 32'd0);
        check("r_mem_addr_f0", 32'(addr1), 32'h0F0);
        clear_log();
        for (int k = 0; k < 8; k++) step(1'b0, 8'($urandom), 1'b0, 1'b0);
        check("r_no_writes", 32'(wcount[0] + wcount[1]), 32'd0);
        send_frame(8'h04, 1'b1, 0, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("r_reload_done", 32'(dn0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
